// File: rtl/tt_um_hoene_led_pwm_multi_pkg.sv
// Shared constants for the multi-channel LED PWM and its neighbours.
// Latency: none (elaboration-time constants and helpers only).
// Backpressure: not applicable.
// Contents: default CHANNELS/WIDTH/PRESCALE values, full-scale helper,
//           per-channel stagger phase offset helper.
package tt_um_hoene_led_pwm_multi_pkg;

  localparam int unsigned DEF_CHANNELS = 3;
  localparam int unsigned DEF_WIDTH    = 10;
  localparam int unsigned DEF_PRESCALE = 1;

  // Largest counter/duty value for a given width: 2^width - 1.
  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Phase offset of channel idx when edges are spread evenly over a period.
  function automatic int unsigned stagger_offset(input int unsigned idx,
                                                 input int unsigned channels,
                                                 input int unsigned width);
    return idx * ((32'd1 << width) / channels);
  endfunction

endpackage

// File: rtl/tt_um_hoene_pwm_channel.sv
// One PWM channel: shadow/active duty pair, load bypass, compare, output flop.
// Latency: out_o is registered, one cycle behind cnt_i; new duty acts after the
//          channel's phase wrap. Backpressure: none, load_i is always accepted.
// Ports: clk_i, rst_i (async, active-high), tick_i (prescaled tick), load_i
//        (duty capture strobe), cnt_i (this channel's phase counter), duty_i,
//        out_o (PWM output), xfer_o (shadow->active transfer this cycle).
module tt_um_hoene_pwm_channel
  import tt_um_hoene_led_pwm_multi_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             out_o,
  output logic             xfer_o
);

  localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(pwm_max(WIDTH));

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             out_q, out_d;

  // Transfer happens on the last tick of this channel's period.
  assign xfer_o = tick_i && (cnt_i == DUTY_MAX);

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (load_i) begin
      shadow_d = duty_i;
    end
    // shadow_d already carries a same-cycle load, so a load coinciding with
    // the transfer bypasses straight into active.
    if (xfer_o) begin
      active_d = shadow_d;
    end
    // All-ones is full-on: no single-tick dropout at cnt == max.
    out_d = (active_q == DUTY_MAX) ? 1'b1 : (cnt_i < active_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      out_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/tt_um_hoene_led_pwm_multi.sv
// Multi-channel LED PWM with prescaler and glitch-free, period-aligned updates.
// Latency: out one cycle behind the counter; loaded duty takes effect after the
//          next period wrap. Backpressure: none, load is always accepted.
// Ports: clk, rst (async, active-high), load (duty capture strobe),
//        duty (packed, channel i = duty[i*WIDTH +: WIDTH]), out (PWM per
//        channel), period_start (pulse in first cnt==0 cycle), pending
//        (shadow holds values not yet transferred).
// Optional: define LED_PWM_STAGGER_EN to give each channel its own phase
//           offset, spreading rising edges across the period.
module tt_um_hoene_led_pwm_multi
  import tt_um_hoene_led_pwm_multi_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_start,
  output logic                      pending
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(pwm_max(WIDTH));
  localparam int unsigned      PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic                tick;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                wrap;
  logic                period_start_q;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] xfer;

  // ---------------------------------------------------------------- prescaler
  generate
    if (PRESCALE == 1) begin : g_no_presc
      assign tick = 1'b1;
    end else begin : g_presc
      localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
      logic [PSW-1:0] presc_q, presc_d;

      always_comb begin
        presc_d = presc_q + PSW'(1);
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          presc_q <= '0;
        end else begin
          presc_q <= presc_d;
        end
      end

      assign tick = (presc_q == PRESC_LAST);
    end
  endgenerate

  // ------------------------------------------------------------ period counter
  assign wrap = tick && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = cnt_q + WIDTH'(1);  // natural modulo-2^WIDTH wrap
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= wrap;
    end
  end

  assign period_start = period_start_q;

  // ------------------------------------------------------------------ channels
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] pcnt;
`ifdef LED_PWM_STAGGER_EN
      localparam logic [WIDTH-1:0] PH_OFF = WIDTH'(stagger_offset(i, CHANNELS, WIDTH));
      assign pcnt = cnt_q + PH_OFF;
`else
      assign pcnt = cnt_q;
`endif
      tt_um_hoene_pwm_channel #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_i (tick),
        .load_i (load),
        .cnt_i  (pcnt),
        .duty_i (duty[i*WIDTH +: WIDTH]),
        .out_o  (out[i]),
        .xfer_o (xfer[i])
      );
    end
  endgenerate

  // ------------------------------------------------------------ pending status
  // One bit per channel so that, with staggered phases, pending only drops
  // once the last channel has taken its update. Without staggering all bits
  // move together. A load landing on a channel's transfer bypasses, so that
  // channel is not left pending.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (xfer[i]) begin
        pend_d[i] = 1'b0;
      end else if (load) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending = |pend_q;

endmodule

// File: tb/tb_tt_um_hoene_led_pwm_multi.sv
// Bench for tt_um_hoene_led_pwm_multi: two instances (PRESCALE 1 and 4,
// 3 channels, 4-bit duty) sharing load/duty, checked every cycle against a
// period-arithmetic reference model plus directed pulse-count windows.
module tb_tt_um_hoene_led_pwm_multi;

  localparam int CH = 3;
  localparam int W  = 4;
  localparam int PERIOD = 1 << W;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   out0, out1;
  logic            ps0, ps1, pend0, pend1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  tt_um_hoene_led_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) dut_p1 (
    .clk(clk), .rst(rst), .load(load), .duty(duty),
    .out(out0), .period_start(ps0), .pending(pend0));

  tt_um_hoene_led_pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(4)) dut_p4 (
    .clk(clk), .rst(rst), .load(load), .duty(duty),
    .out(out1), .period_start(ps1), .pending(pend1));

  // ------------------------------------------------------------ reference model
  int         presc [2] = '{1, 4};
  int         m_c   [2];          // cycles elapsed since reset release
  int         m_sh  [2][CH];
  int         m_act [2][CH];
  bit [CH-1:0] m_pb [2];
  logic [CH-1:0] e_out [2];
  logic       e_ps  [2];
  logic       e_pend[2];

  // observed-activity counters for directed windows
  int hi0 [CH];
  int hi1;
  int nps0, nps1;

  function automatic int off(input int i);
`ifdef LED_PWM_STAGGER_EN
    return i * (PERIOD / CH);
`else
    return 0 * i;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_c[d] = 0;
      m_pb[d] = '0;
      e_out[d] = '0;
      e_ps[d] = 1'b0;
      e_pend[d] = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_sh[d][i] = 0;
        m_act[d][i] = 0;
      end
    end
  endtask

  // Advance instance d by one clock cycle with the given inputs; leaves the
  // outputs expected right after that cycle's edge.
  task automatic model_cycle(input int d, input bit ld, input logic [CH*W-1:0] dv);
    int p, cnt, pc, nd;
    bit tk;
    bit wr [CH];
    p   = presc[d];
    cnt = (m_c[d] / p) % PERIOD;
    tk  = (m_c[d] % p) == p - 1;
    e_ps[d] = tk && (cnt == PERIOD - 1);
    for (int i = 0; i < CH; i++) begin
      pc = (cnt + off(i)) % PERIOD;
      e_out[d][i] = (m_act[d][i] == PERIOD - 1) || (pc < m_act[d][i]);
      wr[i] = tk && (pc == PERIOD - 1);
    end
    for (int i = 0; i < CH; i++) begin
      nd = int'(dv[i*W +: W]);
      if (wr[i]) begin
        m_act[d][i] = ld ? nd : m_sh[d][i];
        m_pb[d][i] = 1'b0;
      end else if (ld) begin
        m_pb[d][i] = 1'b1;
      end
      if (ld) m_sh[d][i] = nd;
    end
    e_pend[d] = |m_pb[d];
    m_c[d]++;
  endtask

  // ------------------------------------------------------------------ stimulus
  task automatic clr_counts();
    for (int i = 0; i < CH; i++) hi0[i] = 0;
    hi1 = 0; nps0 = 0; nps1 = 0;
  endtask

  // Called at a falling edge: check current outputs, apply inputs for the
  // next cycle, advance the model, wait for the next falling edge.
  task automatic step(input bit ld, input logic [CH*W-1:0] dv);
    check("p1_out",  32'(out0),  32'(e_out[0]));
    check("p1_ps",   32'(ps0),   32'(e_ps[0]));
    check("p1_pend", 32'(pend0), 32'(e_pend[0]));
    check("p4_out",  32'(out1),  32'(e_out[1]));
    check("p4_ps",   32'(ps1),   32'(e_ps[1]));
    check("p4_pend", 32'(pend1), 32'(e_pend[1]));
    for (int i = 0; i < CH; i++) hi0[i] += int'(out0[i]);
    hi1  += int'(out1[0]);
    nps0 += int'(ps0);
    nps1 += int'(ps1);
    load = ld;
    duty = dv;
    model_cycle(0, ld, dv);
    model_cycle(1, ld, dv);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0);
  endtask

  // Idle until the PRESCALE=1 instance's next cycle has counter value ph.
  task automatic to_phase(input int ph);
    for (int k = 0; k < PERIOD; k++) begin
      if ((m_c[0] % PERIOD) == ph) break;
      step(1'b0, '0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; duty = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    do_reset();

    // Reset then idle
    check("rst_out", 32'(out0), 32'd0);
    check("rst_pend", 32'(pend0), 32'd0);
    clr_counts();
    run(40);
    check("idle_hi0", 32'(hi0[0] + hi0[1] + hi0[2]), 32'd0);
    check("idle_nps_p1", 32'(nps0), 32'd2);
    check("idle_nps_p4", 32'(nps1), 32'd0);

    // Mid-period load 5/0/15
    to_phase(7);
    step(1'b1, 12'hF05);
    check("mid_pend_set", 32'(pend0), 32'd1);
    to_phase(0);
    check("mid_pend_clr", 32'(pend0), 32'd0);
    step(1'b0, '0);
    clr_counts();
    run(PERIOD);
    check("mid_ch0_hi", 32'(hi0[0]), 32'd5);
    check("mid_ch1_hi", 32'(hi0[1]), 32'd0);
    check("mid_ch2_hi", 32'(hi0[2]), 32'(PERIOD));

    // Load coinciding with the wrap bypasses into active
    to_phase(PERIOD - 1);
    step(1'b1, 12'h008);
    check("ldwrap_pend", 32'(pend0), 32'd0);
    step(1'b0, '0);
    clr_counts();
    run(PERIOD);
    check("ldwrap_ch0_hi", 32'(hi0[0]), 32'd8);

    // Two loads in one period: last one wins
    to_phase(2);
    step(1'b1, 12'h003);
    to_phase(6);
    step(1'b1, 12'h009);
    check("dbl_pend", 32'(pend0), 32'd1);
    to_phase(0);
    step(1'b0, '0);
    clr_counts();
    run(PERIOD);
    check("dbl_ch0_hi", 32'(hi0[0]), 32'd9);

    // Prescaled instance, duty 2: steady-state 64-cycle window
    step(1'b1, 12'h222);
    run(140);
    clr_counts();
    run(64);
    check("p4_hi", 32'(hi1), 32'd8);
    check("p4_nps", 32'(nps1), 32'd1);
    check("p1_hi64", 32'(hi0[0]), 32'd8);
    check("p1_nps64", 32'(nps0), 32'd4);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic [CH*W-1:0] dv;
      dv = CH*W'($urandom);
      step($urandom_range(0, 7) == 0, dv);
    end

    // Reset while mid-pulse with an update pending
    to_phase(0);
    step(1'b1, 12'h00C);
    to_phase(0);
    run(2);
    step(1'b1, 12'h005);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out0[0] === 1'b1 && pend0 === 1'b1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, '0);
    end
    check("arst_setup", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_out_p1", 32'(out0), 32'd0);
    check("arst_out_p4", 32'(out1), 32'd0);
    check("arst_pend", 32'(pend0), 32'd0);
    check("arst_ps", 32'(ps0), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    duty = '0;
    model_reset();
    clr_counts();
    run(40);
    check("arst_active0", 32'(hi0[0] + hi0[1] + hi0[2]), 32'd0);
    check("arst_pend_after", 32'(pend0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
